opcode_decode_pipe: RTL and testbench
=====================================

// Module: opcode_decode_pipe
// PURPOSE
//  Parametrised, pipelined one-hot opcode decoder for the ALU front end. Takes a
//  one-hot opcode with valid/ready handshake and emits a registered operation
//  index to the ALU core. Adds a priority/strict decode mode, illegal-opcode
//  flagging and a saturating illegal-opcode counter with clear.
// PARAMETERS
//  OPW      6  opcode width (one-hot field), >=2
//  OPSELW   3  operation index width; must satisfy 2**OPSELW >= OPW+2
//  PRIORITY 0  0 = strict (multi-hot is illegal), 1 = MSB-first priority decode
//  CNTW     8  illegal-opcode counter width
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       opcode present on in_opcode
//  in_ready   out  1       decoder accepts opcode this cycle
//  in_opcode  in   OPW     one-hot opcode (all-zero also legal)
//  out_valid  out  1       out_op/out_illegal valid
//  out_ready  in   1       ALU core consumes result this cycle
//  out_op     out  OPSELW  decoded operation index
//  out_illegal out 1       opcode was illegal (out_op = ILLEGAL)
//  cnt_clr    in   1       clear illegal counter and sticky flag
//  ill_cnt    out  CNTW    saturating count of accepted illegal opcodes
//  ill_sticky out  1       set on first accepted illegal opcode, held until clear
// BEHAVIOUR
//  - Decode map: opcode==0 -> 0; bit k set alone -> OPW-k (bit OPW-1 -> 1,
//    bit 0 -> OPW); anything else -> ILLEGAL = 2**OPSELW-1, out_illegal=1.
//    OPW=6: 000000->0, 100000->1, 010000->2 ... 000001->6, other->7.
//  - PRIORITY=1: multi-hot decodes by highest set bit (110000 -> 1), never illegal;
//    ill_cnt/ill_sticky then stay 0.
//  - Handshake: transfer on in_valid&&in_ready / out_valid&&out_ready.
//    in_ready = !out_valid || out_ready (combinational, no in_valid dependence).
//  - Latency 1 cycle: accepted opcode appears on out_* next cycle. Throughput
//    1/cycle under continuous out_ready. out_* held stable while out_valid&&!out_ready.
//  - out_valid: set on accept; cleared when consumed with no new accept same cycle;
//    stays 1 on simultaneous consume+accept (new data loaded).
//  - Illegal counter: increments by 1 per ACCEPTED illegal opcode (at input
//    transfer, not output); saturates at 2**CNTW-1, never wraps.
//  - cnt_clr has priority over increment in the same cycle: result cnt=0,
//    sticky=0 (the simultaneous illegal is dropped from count).
//  - Reset: out_valid=0, out_op=0, out_illegal=0, ill_cnt=0, ill_sticky=0;
//    in_ready=1 in the cycle after reset. Reset mid-transfer discards held
//    result; no output transfer occurs while rst=1 (in_ready forced 0 during rst).
//  - in_opcode with in_valid=0 ignored: no count, no state change.
// STRUCTURE
//  - Shared package/include: ALU op index constants (OP_NOP=0 ... ILLEGAL),
//    mode constants STRICT/PRIORITY, OPSELW check helper.
//  - One sub-module: onehot_op_decode (pure combinational map incl. mode),
//    reusable by the ALU core; this block wraps it with the output register,
//    handshake and counter.
//  - Elaboration check: error if 2**OPSELW < OPW+2.
// TESTING
//  1 Reset then in 000000..000001 each single cycle, out_ready=1 -> out_op
//    0,1,2,3,4,5,6 one cycle later, back-to-back, out_illegal=0.
//  2 STRICT: in 110000, 111111 -> out_op=7, out_illegal=1, ill_cnt=2, sticky=1;
//    PRIORITY build: 110000 -> 1, 000011 -> 5, ill_cnt stays 0.
//  3 Backpressure: out_ready=0 for 3 cycles after accepting 001000 -> out_op=3
//    held, in_ready=0; new input 000100 held by source; release -> 3 then 4, none lost.
//  4 CNTW=2: 5 accepted illegals -> ill_cnt 1,2,3,3,3; cnt_clr with illegal
//    same cycle -> ill_cnt=0, sticky=0.
//  5 Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0,
//    ill_cnt=0, in_ready=1; held result never transferred.
//  6 Random valid/ready toggling, 1000 opcodes vs scoreboard model -> order and
//    values match, ill_cnt equals model count (saturated).

Source files
------------

// File: rtl/opcode_decode_pipe_pkg.sv
// opcode_decode_pipe_pkg: shared ALU op indices, decode modes and width check
package opcode_decode_pipe_pkg;
  typedef enum logic [2:0] {
    OP_NOP, OP_1, OP_2, OP_3, OP_4, OP_5, OP_6, OP_ILLEGAL
  } alu_op_e;
  localparam int MODE_STRICT = 0;
  localparam int MODE_PRIORITY = 1;
  function automatic bit opselw_ok(input int opw, input int opselw);
    return (1 << opselw) >= opw + 2;
  endfunction
endpackage

// File: rtl/opcode_decode_pipe_onehot_op_decode.sv
// onehot_op_decode: combinational one-hot opcode to operation index map
module onehot_op_decode
  import opcode_decode_pipe_pkg::*;
#(
  parameter int OPW = 6,
  parameter int OPSELW = 3,
  parameter int PRIORITY = MODE_STRICT
) (
  input  logic [OPW-1:0]    opcode,
  output logic [OPSELW-1:0] op,
  output logic              illegal
);
  logic [OPSELW-1:0] hi;
  logic multi;
  always_comb begin
    hi = OPSELW'(OP_NOP);
    for (int k = 0; k < OPW; k++) if (opcode[k]) hi = OPSELW'(OPW - k);
    multi = |(opcode & (opcode - OPW'(1)));
    illegal = (PRIORITY == MODE_PRIORITY) ? 1'b0 : multi;
    op = illegal ? '1 : hi;
  end
endmodule

// File: rtl/opcode_decode_pipe.sv
// opcode_decode_pipe: registered one-hot opcode decoder with handshake and illegal counter
module opcode_decode_pipe
  import opcode_decode_pipe_pkg::*;
#(
  parameter int OPW = 6,
  parameter int OPSELW = 3,
  parameter int PRIORITY = MODE_STRICT,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    in_opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPSELW-1:0] out_op,
  output logic              out_illegal,
  input  logic              cnt_clr,
  output logic [CNTW-1:0]   ill_cnt,
  output logic              ill_sticky
);
  if (OPW < 2 || !opselw_ok(OPW, OPSELW)) begin : g_bad_params
    $error("opcode_decode_pipe: need OPW>=2 and 2**OPSELW >= OPW+2");
  end
  logic [OPSELW-1:0] dec_op;
  logic dec_ill;
  logic acc;
  onehot_op_decode #(.OPW(OPW), .OPSELW(OPSELW), .PRIORITY(PRIORITY)) u_dec (
    .opcode(in_opcode),
    .op(dec_op),
    .illegal(dec_ill)
  );
  assign in_ready = !rst && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op <= '0;
      out_illegal <= 1'b0;
      ill_cnt <= '0;
      ill_sticky <= 1'b0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_op <= dec_op;
        out_illegal <= dec_ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // clear wins over a simultaneous illegal accept
      if (cnt_clr) begin
        ill_cnt <= '0;
        ill_sticky <= 1'b0;
      end else if (acc && dec_ill) begin
        ill_cnt <= ill_cnt + CNTW'(ill_cnt != '1);
        ill_sticky <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_opcode_decode_pipe.sv
// tb_opcode_decode_pipe: scoreboard bench over strict, priority and narrow-counter builds
module tb_opcode_decode_pipe;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic [5:0] in_opcode = '0;
  logic out_ready = 1;
  logic cnt_clr = 0;
  logic ir_s, ir_p, ir_c;
  logic ov_s, ov_p, ov_c;
  logic [2:0] op_s, op_p, op_c;
  logic il_s, il_p, il_c;
  logic [7:0] cnt_s, cnt_p;
  logic [1:0] cnt_c;
  logic st_s, st_p, st_c;
  int checks = 0;
  int errors = 0;
  logic [3:0] qs[$], qp[$], qc[$];
  int m_s = 0, m_c = 0;
  bit done = 0;

  always #5 clk = ~clk;

  opcode_decode_pipe u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s), .in_opcode(in_opcode),
    .out_valid(ov_s), .out_ready(out_ready), .out_op(op_s), .out_illegal(il_s),
    .cnt_clr(cnt_clr), .ill_cnt(cnt_s), .ill_sticky(st_s)
  );
  opcode_decode_pipe #(.PRIORITY(1)) u_p (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_p), .in_opcode(in_opcode),
    .out_valid(ov_p), .out_ready(out_ready), .out_op(op_p), .out_illegal(il_p),
    .cnt_clr(cnt_clr), .ill_cnt(cnt_p), .ill_sticky(st_p)
  );
  opcode_decode_pipe #(.CNTW(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_opcode(in_opcode),
    .out_valid(ov_c), .out_ready(out_ready), .out_op(op_c), .out_illegal(il_c),
    .cnt_clr(cnt_clr), .ill_cnt(cnt_c), .ill_sticky(st_c)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model(input logic [5:0] o, input bit prio);
    int n;
    n = $countones(o);
    if (n == 0) return 4'd0;
    if (n > 1 && !prio) return 4'b1111;
    for (int k = 5; k >= 0; k--) if (o[k]) return {1'b0, 3'(6 - k)};
    return 4'd0;
  endfunction

  // scoreboard monitor: pops one entry per output transfer of each build
  initial forever begin
    @(negedge clk);
    if (!rst && out_ready) begin
      if (ov_s) begin
        if (qs.size() == 0) chk("pop_s_empty", {il_s, op_s}, 8'hee);
        else chk("out_s", {4'd0, il_s, op_s}, {4'd0, qs.pop_front()});
      end
      if (ov_p) begin
        if (qp.size() == 0) chk("pop_p_empty", {il_p, op_p}, 8'hee);
        else chk("out_p", {4'd0, il_p, op_p}, {4'd0, qp.pop_front()});
      end
      if (ov_c) begin
        if (qc.size() == 0) chk("pop_c_empty", {il_c, op_c}, 8'hee);
        else chk("out_c", {4'd0, il_c, op_c}, {4'd0, qc.pop_front()});
      end
    end
  end

  task automatic send(input logic [5:0] o, input logic [3:0] es, input logic [3:0] ep);
    int n = 0;
    in_valid = 1;
    in_opcode = o;
    @(negedge clk);
    while (!ir_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ir_s) begin
      errors++;
      $display("FAIL accept_timeout opcode %b never accepted", o);
    end else begin
      qs.push_back(es);
      qc.push_back(es);
      qp.push_back(ep);
      if (es[3]) begin
        m_s = (m_s == 255) ? 255 : m_s + 1;
        m_c = (m_c == 3) ? 3 : m_c + 1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_ov"}, {5'd0, ov_s, ov_p, ov_c}, 8'd0);
    chk({tag, "_ir"}, {5'd0, ir_s, ir_p, ir_c}, 8'd7);
    chk({tag, "_cnt_s"}, cnt_s, 8'd0);
    chk({tag, "_cnt_c"}, {6'd0, cnt_c}, 8'd0);
    chk({tag, "_sticky"}, {5'd0, st_s, st_p, st_c}, 8'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst = 0;
    @(negedge clk);
    check_idle_state("reset");
    chk("reset_out", {2'd0, op_s, il_s, il_p, il_c}, 8'd0);
    // back-to-back legal opcodes
    idle(1);
    send(6'b000000, 4'd0, 4'd0);
    send(6'b100000, 4'd1, 4'd1);
    send(6'b010000, 4'd2, 4'd2);
    send(6'b001000, 4'd3, 4'd3);
    send(6'b000100, 4'd4, 4'd4);
    send(6'b000010, 4'd5, 4'd5);
    send(6'b000001, 4'd6, 4'd6);
    idle(2);
    chk("legal_cnt_s", cnt_s, 8'd0);
    // multi-hot: illegal in strict, priority in priority build
    send(6'b110000, 4'b1111, 4'd1);
    send(6'b111111, 4'b1111, 4'd1);
    idle(2);
    chk("ill2_cnt_s", cnt_s, 8'd2);
    chk("ill2_sticky_s", {7'd0, st_s}, 8'd1);
    send(6'b000011, 4'b1111, 4'd5);
    idle(2);
    chk("ill3_cnt_s", cnt_s, 8'd3);
    chk("ill3_cnt_c", {6'd0, cnt_c}, 8'd3);
    chk("prio_cnt", cnt_p, 8'd0);
    chk("prio_sticky", {7'd0, st_p}, 8'd0);
    cnt_clr = 1;
    idle(1);
    cnt_clr = 0;
    chk("clr_cnt_s", cnt_s, 8'd0);
    chk("clr_sticky", {6'd0, st_s, st_c}, 8'd0);
    // backpressure
    send(6'b001000, 4'd3, 4'd3);
    out_ready = 0;
    in_valid = 1;
    in_opcode = 6'b000100;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", {3'd0, ov_s, il_s, op_s}, 8'h13);
      chk("bp_in_ready", {7'd0, ir_s}, 8'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    send(6'b000100, 4'd4, 4'd4);
    idle(3);
    chk("bp_drain", 8'(qs.size() + qp.size() + qc.size()), 8'd0);
    // saturating narrow counter, then clear colliding with an illegal
    for (int i = 0; i < 5; i++) begin
      send(6'b101000, 4'b1111, 4'd1);
      chk("sat_cnt_c", {6'd0, cnt_c}, (i < 3) ? 8'(i + 1) : 8'd3);
      chk("sat_cnt_s", cnt_s, 8'(i + 1));
    end
    cnt_clr = 1;
    send(6'b011000, 4'b1111, 4'd2);
    cnt_clr = 0;
    chk("clr_coll_cnt", {cnt_s[5:0], cnt_c}, 8'd0);
    chk("clr_coll_sticky", {6'd0, st_s, st_c}, 8'd0);
    idle(2);
    // reset while a result is held
    out_ready = 0;
    send(6'b100001, 4'b1111, 4'd1);
    @(negedge clk);
    chk("pre_rst_ov", {7'd0, ov_s}, 8'd1);
    chk("pre_rst_cnt", cnt_s, 8'd1);
    @(posedge clk);
    #1;
    rst = 1;
    qs.delete();
    qp.delete();
    qc.delete();
    m_s = 0;
    m_c = 0;
    @(negedge clk);
    chk("rst_in_ready", {5'd0, ir_s, ir_p, ir_c}, 8'd0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_idle_state("post_rst");
    out_ready = 1;
    idle(3);
    // random valid/ready traffic against the model
    fork
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [5:0] o;
          int r;
          r = $urandom_range(0, 3);
          o = (r == 0) ? 6'd0 : (r == 3) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
          repeat ($urandom_range(0, 2)) begin
            in_opcode = 6'($urandom);
            idle(1);
          end
          send(o, model(o, 0), model(o, 1));
        end
        done = 1;
      end
    join
    out_ready = 1;
    idle(4);
    chk("rand_drain", 8'(qs.size() + qp.size() + qc.size()), 8'd0);
    chk("rand_cnt_s", cnt_s, 8'(m_s));
    chk("rand_cnt_c", {6'd0, cnt_c}, 8'(m_c));
    chk("rand_cnt_p", cnt_p, 8'd0);
    chk("rand_sticky", {5'd0, st_s, st_p, st_c}, {5'd0, m_s != 0, 1'b0, m_c != 0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
